// File: rtl/sync_reg_xfer_queue.sv
// Multi-channel register-update queue feeding a 4-phase req/ack handshake.
// Per-channel pending registers -> round-robin arbiter -> circular queue -> handshake FSM.
module sync_reg_xfer_queue #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int QW   = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_strobe,
  input  logic [NCH*WIDTH-1:0] in_reg,
  output logic [NCH-1:0]       ovf,
  input  logic [NCH-1:0]       ovf_clr,
  output logic [QW-1:0]        q_count,
  output logic                 xfer_req,
  output logic [WIDTH-1:0]     xfer_data,
  output logic [CW-1:0]        xfer_chan,
  input  logic                 xfer_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t             state_q, state_d;
  logic [NCH-1:0]     pend_v_q, pend_v_d;
  logic [WIDTH-1:0]   pend_data_q [NCH];
  logic [NCH-1:0]     ovf_q, ovf_d;
  logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW+WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [QW-1:0]      count_q, count_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   data_q;
  logic [CW-1:0]      chan_q;

  logic               gnt_v;
  logic [CW-1:0]      gnt_idx;
  logic               push, pop, full;
  logic [NCH-1:0]     drain;

  assign full = (count_q == QW'(DEPTH));

  // Walk offsets downward so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_v_q[(int'(rr_ptr_q) + i) % NCH]) begin
        gnt_v   = 1'b1;
        gnt_idx = CW'((int'(rr_ptr_q) + i) % NCH);
      end
    end
  end

  // A pop in the same cycle frees the slot a full queue needs.
  assign push = gnt_v && (!full || pop);

  always_comb begin
    drain    = '0;
    pend_v_d = pend_v_q;
    ovf_d    = ovf_q & ~ovf_clr;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      drain[gnt_idx] = 1'b1;
      rr_ptr_d       = CW'((int'(gnt_idx) + 1) % NCH);
    end
    for (int k = 0; k < NCH; k++) begin
      if (in_strobe[k]) begin
        pend_v_d[k] = 1'b1;
        if (pend_v_q[k] && !drain[k]) ovf_d[k] = 1'b1;
      end else if (drain[k]) begin
        pend_v_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + QW'(1);
      2'b01:   count_d = count_q - QW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_v_q <= '0;
      ovf_q    <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      req_q    <= req_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        {chan_q, data_q} <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage only; validity is tracked by pend_v_q and the queue pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (in_strobe[k]) pend_data_q[k] <= in_reg[k*WIDTH +: WIDTH];
    end
    if (push) mem_q[wr_ptr_q] <= {gnt_idx, pend_data_q[gnt_idx]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0 && !xfer_ack) state_d = S_REQ;
      S_REQ:   if (xfer_ack) state_d = S_REL;
      S_REL:   if (!xfer_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    req_d = req_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !xfer_ack) begin
          pop   = 1'b1;
          req_d = 1'b1;
        end
      end
      S_REQ:   if (xfer_ack) req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
  end

  assign ovf       = ovf_q;
  assign q_count   = count_q;
  assign xfer_req  = req_q;
  assign xfer_data = data_q;
  assign xfer_chan = chan_q;

endmodule
